// File: rtl/fib_pkg.sv
// Shared defaults, FSM state encoding and FIFO entry layout for the Fibonacci sweep controller.
package fib_pkg;

   localparam int unsigned DEF_W       = 10;
   localparam int unsigned DEF_DEPTH   = 4;
   localparam int unsigned DEF_TIMEOUT = 1023;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_NEXT,
      S_FINISH
   } state_t;

   typedef struct packed {
      logic [DEF_W-1:0] index;
      logic [DEF_W-1:0] result;
   } entry_t;

endpackage

// File: rtl/fib_sweep_ctrl_if.sv
// Fibonacci-unit request handshake plus the result stream port of the sweep controller.
interface fib_sweep_ctrl_if
   import fib_pkg::*;
#(
   parameter int unsigned W = DEF_W
);

   logic         FibRst;
   logic         FibStart;
   logic [W-1:0] FibNumber;
   logic [W-1:0] FibResult;
   logic         FibDone;
   logic         OutValid;
   logic         OutReady;
   logic [W-1:0] OutIndex;
   logic [W-1:0] OutResult;

   modport master (
      output FibRst, FibStart, FibNumber, OutValid, OutIndex, OutResult,
      input  FibResult, FibDone, OutReady
   );

   modport slave (
      input  FibRst, FibStart, FibNumber, OutValid, OutIndex, OutResult,
      output FibResult, FibDone, OutReady
   );

endinterface

// File: rtl/fib_result_fifo.sv
// Synchronous show-ahead FIFO; head reads as zero while empty.
module fib_result_fifo #(
   parameter int unsigned DW    = 20,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     push,
   input  logic [DW-1:0]            push_data,
   input  logic                     pop,
   output logic [DW-1:0]            head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge Clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fib_sweep_ctrl.sv
// Steps the Fibonacci unit over First..Last, one request at a time, and streams {index, result}.
module fib_sweep_ctrl
   import fib_pkg::*;
#(
   parameter int unsigned W       = DEF_W,
   parameter int unsigned DEPTH   = DEF_DEPTH,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 Go,
   input  logic [W-1:0]         First,
   input  logic [W-1:0]         Last,
   fib_sweep_ctrl_if.master     bus,
   output logic                 Busy,
   output logic                 SweepDone,
   output logic                 Error
);

   localparam int unsigned WDW = $clog2(TIMEOUT + 1);
   localparam int unsigned CW  = $clog2(DEPTH) + 1;
   localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
   localparam logic [CW-1:0]  FULL_CNT = DEPTH[CW-1:0];

   state_t         state;
   logic [W-1:0]   idx;
   logic [W-1:0]   last;
   logic [WDW-1:0] wd;

   logic           push;
   logic           pop;
   logic           full;
   logic           empty;
   logic [2*W-1:0] head;
   logic [CW-1:0]  count;

   assign push          = (state == S_RUN) && bus.FibDone;
   assign pop           = !empty && bus.OutReady;
   assign bus.FibNumber = idx;
   assign bus.OutValid  = !empty;
   assign bus.OutIndex  = head[2*W-1:W];
   assign bus.OutResult = head[W-1:0];

   fib_result_fifo #(
      .DW    (2 * W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .Clk       (Clk),
      .Rst       (Rst),
      .push      (push),
      .push_data ({idx, bus.FibResult}),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state        <= S_IDLE;
         idx          <= '0;
         last         <= '0;
         wd           <= '0;
         bus.FibRst   <= 1'b1;
         bus.FibStart <= 1'b0;
         Busy         <= 1'b0;
         SweepDone    <= 1'b0;
         Error        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (Go) begin
                  if (First > Last) begin
                     Error <= 1'b1;
                  end else begin
                     idx   <= First;
                     last  <= Last;
                     wd    <= '0;
                     Error <= 1'b0;
                     Busy  <= 1'b1;
                     state <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               bus.FibRst   <= 1'b0;
               bus.FibStart <= 1'b1;
               state        <= S_RUN;
            end
            S_RUN: begin
               // wd counts completed RUN cycles, so the abort lands on the TIMEOUT-th one
               if (bus.FibDone) begin
                  bus.FibRst   <= 1'b1;
                  bus.FibStart <= 1'b0;
                  state        <= S_NEXT;
               end else if (wd == WD_LAST) begin
                  bus.FibRst   <= 1'b1;
                  bus.FibStart <= 1'b0;
                  Error        <= 1'b1;
                  Busy         <= 1'b0;
                  state        <= S_IDLE;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            S_NEXT: begin
               if (idx == last) begin
                  SweepDone <= 1'b1;
                  Busy      <= 1'b0;
                  state     <= S_FINISH;
               end else if (!full) begin
                  idx   <= idx + 1'b1;
                  wd    <= '0;
                  state <= S_LOAD;
               end
            end
            S_FINISH: begin
               SweepDone <= 1'b0;
               state     <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   a_no_push_when_full: assert property (@(posedge Clk) disable iff (Rst) !(push && full));
   a_count_bound:       assert property (@(posedge Clk) disable iff (Rst) count <= FULL_CNT);

endmodule

// File: tb/tb_fib_sweep_ctrl.sv
// Directed bench for fib_sweep_ctrl with a stub Fibonacci unit and a stream scoreboard.
module tb_fib_sweep_ctrl;
   import fib_pkg::*;

   localparam int unsigned W       = 10;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TIMEOUT = 15;

   logic         Clk   = 1'b0;
   logic         Rst   = 1'b1;
   logic         Go    = 1'b0;
   logic [W-1:0] First = '0;
   logic [W-1:0] Last  = '0;
   logic         Busy;
   logic         SweepDone;
   logic         Error;

   fib_sweep_ctrl_if #(.W(W)) bus();

   fib_sweep_ctrl #(
      .W       (W),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Go        (Go),
      .First     (First),
      .Last      (Last),
      .bus       (bus.master),
      .Busy      (Busy),
      .SweepDone (SweepDone),
      .Error     (Error)
   );

   always #5 Clk = ~Clk;

   function automatic logic [W-1:0] fibw(input logic [W-1:0] n);
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] t;
      a = '0;
      b = 1;
      for (int i = 0; i < int'(n); i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Stub unit: done level appears a few cycles after start, latency varies with the operand
   logic         hang = 1'b0;
   logic         stub_done;
   logic [W-1:0] stub_res;
   int           stub_cnt;

   always @(posedge Clk) begin
      if (bus.FibRst) begin
         stub_done <= 1'b0;
         stub_res  <= '0;
         stub_cnt  <= 0;
      end else if (bus.FibStart && !stub_done && !hang) begin
         if (stub_cnt == int'(bus.FibNumber % 4) + 1) begin
            stub_done <= 1'b1;
            stub_res  <= fibw(bus.FibNumber);
         end else begin
            stub_cnt <= stub_cnt + 1;
         end
      end
   end

   assign bus.FibDone   = stub_done;
   assign bus.FibResult = stub_res;

   int     checks   = 0;
   int     failures = 0;
   entry_t exp_q[$];
   entry_t rx[64];
   int     rx_n        = 0;
   int     sd_cnt      = 0;
   int     start_rises = 0;
   int     run_cycles  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic start_sweep(input int f, input int l, input bit expect_entries);
      if (expect_entries) begin
         for (int i = f; i <= l; i++) begin
            exp_q.push_back('{index: W'(i), result: fibw(W'(i))});
         end
      end
      First = W'(f);
      Last  = W'(l);
      Go    = 1'b1;
      tick();
      Go    = 1'b0;
   endtask

   task automatic wait_sweep_done(input string name, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (SweepDone) begin
            seen = 1'b1;
            break;
         end
      end
      chk({name, "_done_seen"}, 32'(seen), 1);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_FibRst"},    32'(bus.FibRst),    1);
      chk({tag, "_FibStart"},  32'(bus.FibStart),  0);
      chk({tag, "_FibNumber"}, 32'(bus.FibNumber), 0);
      chk({tag, "_OutValid"},  32'(bus.OutValid),  0);
      chk({tag, "_OutIndex"},  32'(bus.OutIndex),  0);
      chk({tag, "_OutResult"}, 32'(bus.OutResult), 0);
      chk({tag, "_Busy"},      32'(Busy),          0);
      chk({tag, "_SweepDone"}, 32'(SweepDone),     0);
      chk({tag, "_Error"},     32'(Error),         0);
   endtask

   initial begin
      int  sd_before;
      int  rises_before;
      bit  any_start;
      bit  found;
      bit  valid_dropped;

      bus.OutReady = 1'b0;

      fork
         begin : compare
            logic         prev_start;
            logic [W-1:0] prev_num;
            entry_t       e;
            prev_start = 1'b0;
            prev_num   = '0;
            forever begin
               @(negedge Clk);
               if (Rst) begin
                  prev_start = 1'b0;
               end else begin
                  if (bus.OutValid) begin
                     chk("head_result", 32'(bus.OutResult), 32'(fibw(bus.OutIndex)));
                  end
                  if (bus.OutValid && bus.OutReady) begin
                     if (exp_q.size() == 0) begin
                        chk("unexpected_entry", 32'(bus.OutIndex), 32'h7fff_ffff);
                     end else begin
                        e = exp_q.pop_front();
                        chk("stream_index",  32'(bus.OutIndex),  32'(e.index));
                        chk("stream_result", 32'(bus.OutResult), 32'(e.result));
                     end
                     if (rx_n < 64) begin
                        rx[rx_n] = '{index: bus.OutIndex, result: bus.OutResult};
                        rx_n++;
                     end
                  end
                  if (bus.FibStart && prev_start) begin
                     chk("number_stable", 32'(bus.FibNumber), 32'(prev_num));
                  end
                  if (SweepDone) begin
                     sd_cnt++;
                     chk("busy_low_at_done", 32'(Busy), 0);
                  end
                  if (bus.FibStart && !prev_start) start_rises++;
                  if (bus.FibStart) run_cycles++;
                  prev_start = bus.FibStart;
                  prev_num   = bus.FibNumber;
               end
            end
         end
      join_none

      // Reset state
      repeat (3) tick();
      check_reset_vals("reset");
      Rst = 1'b0;
      tick();

      // Sweep 1..5, consumer always ready
      bus.OutReady = 1'b1;
      rx_n = 0;
      sd_before = sd_cnt;
      start_sweep(1, 5, 1'b1);
      chk("load_FibRst",    32'(bus.FibRst),    1);
      chk("load_FibStart",  32'(bus.FibStart),  0);
      chk("load_FibNumber", 32'(bus.FibNumber), 1);
      chk("load_Busy",      32'(Busy),          1);
      tick();
      chk("run_FibStart",   32'(bus.FibStart),  1);
      chk("run_FibRst",     32'(bus.FibRst),    0);
      wait_sweep_done("s1_5", 400);
      chk("s1_5_busy_at_done", 32'(Busy),  0);
      chk("s1_5_error",        32'(Error), 0);
      repeat (3) tick();
      chk("s1_5_done_pulses", 32'(sd_cnt - sd_before), 1);
      chk("s1_5_drained",     32'(exp_q.size()), 0);
      chk("s1_5_count",       32'(rx_n), 5);
      chk("s1_5_e0", {rx[0].index, rx[0].result}, {10'd1, 10'd1});
      chk("s1_5_e1", {rx[1].index, rx[1].result}, {10'd2, 10'd1});
      chk("s1_5_e2", {rx[2].index, rx[2].result}, {10'd3, 10'd2});
      chk("s1_5_e3", {rx[3].index, rx[3].result}, {10'd4, 10'd3});
      chk("s1_5_e4", {rx[4].index, rx[4].result}, {10'd5, 10'd5});

      // Single-entry sweep
      rx_n = 0;
      rises_before = start_rises;
      start_sweep(10, 10, 1'b1);
      wait_sweep_done("s10", 200);
      repeat (2) tick();
      chk("s10_start_rises", 32'(start_rises - rises_before), 1);
      chk("s10_count", 32'(rx_n), 1);
      chk("s10_e0", {rx[0].index, rx[0].result}, {10'd10, 10'd55});

      // Backpressure: FIFO fills and the FSM parks
      bus.OutReady = 1'b0;
      rx_n = 0;
      start_sweep(1, 8, 1'b1);
      repeat (60) tick();
      chk("park_FibNumber", 32'(bus.FibNumber), 4);
      chk("park_FibStart",  32'(bus.FibStart),  0);
      chk("park_FibRst",    32'(bus.FibRst),    1);
      chk("park_OutValid",  32'(bus.OutValid),  1);
      chk("park_head",      {bus.OutIndex, bus.OutResult}, {10'd1, 10'd1});
      chk("park_Busy",      32'(Busy),          1);
      any_start     = 1'b0;
      valid_dropped = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.FibStart) any_start = 1'b1;
         if (!bus.OutValid) valid_dropped = 1'b1;
      end
      chk("park_no_start",    32'(any_start),     0);
      chk("park_valid_held",  32'(valid_dropped), 0);
      bus.OutReady = 1'b1;
      wait_sweep_done("s1_8", 600);
      tick();
      chk("s1_8_drained", 32'(exp_q.size()), 0);
      chk("s1_8_count",   32'(rx_n), 8);
      chk("s1_8_e7", {rx[7].index, rx[7].result}, {10'd8, 10'd21});

      // Watchdog abort with a unit that never finishes
      hang = 1'b1;
      run_cycles = 0;
      start_sweep(3, 5, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (Error) begin
            found = 1'b1;
            break;
         end
      end
      chk("timeout_error",      32'(found), 1);
      chk("timeout_run_cycles", 32'(run_cycles), TIMEOUT);
      chk("timeout_busy",       32'(Busy), 0);
      chk("timeout_FibRst",     32'(bus.FibRst), 1);
      chk("timeout_no_push",    32'(bus.OutValid), 0);
      hang = 1'b0;
      rx_n = 0;
      start_sweep(2, 3, 1'b1);
      chk("go_clears_error", 32'(Error), 0);
      wait_sweep_done("s2_3", 200);
      tick();
      chk("s2_3_count", 32'(rx_n), 2);

      // Reversed range
      run_cycles = 0;
      start_sweep(7, 3, 1'b0);
      chk("reverse_error", 32'(Error), 1);
      chk("reverse_busy",  32'(Busy), 0);
      any_start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.FibStart || Busy) any_start = 1'b1;
      end
      chk("reverse_no_start", 32'(any_start), 0);

      // Reset mid-sweep with two entries buffered
      bus.OutReady = 1'b0;
      start_sweep(1, 20, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (bus.FibStart && bus.FibNumber == 3) begin
            found = 1'b1;
            break;
         end
      end
      chk("midrst_reached_run3", 32'(found), 1);
      chk("midrst_buffered_head", {bus.OutIndex, bus.OutResult}, {10'd1, 10'd1});
      Rst = 1'b1;
      tick();
      check_reset_vals("midrst");
      Rst = 1'b0;
      exp_q.delete();
      tick();
      bus.OutReady = 1'b1;
      rx_n = 0;
      start_sweep(4, 6, 1'b1);
      chk("restart_FibNumber", 32'(bus.FibNumber), 4);
      wait_sweep_done("s4_6", 300);
      tick();
      chk("s4_6_count", 32'(rx_n), 3);
      chk("s4_6_e0", {rx[0].index, rx[0].result}, {10'd4, 10'd3});
      chk("s4_6_e2", {rx[2].index, rx[2].result}, {10'd6, 10'd8});
      chk("s4_6_drained", 32'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fib_sweep_ctrl.md
# fib_sweep_ctrl

Hardware initiator for the Fibonacci unit's Start/Number/Result/Done handshake. On a Go command it steps Number from First to Last and runs one request per value. Each result is buffered with its index in a small FIFO and streamed out over a valid/ready port. It replaces the software/bench sweep loop, so the Fibonacci unit can be exercised on silicon and fed to downstream logic.

## Interface
- W, 10, width of Number/Result/index
- DEPTH, 4, result FIFO depth (power of two, ≥2)
- TIMEOUT, 1023, max cycles in RUN waiting for FibDone before abort
- Clk  input  1  clock, all logic on rising edge
- Rst  input  1  reset, synchronous, active-high
- Go  input  1  start sweep; sampled only in IDLE
- First, Last  input  W  inclusive index range; sampled with Go
- FibRst  output  1  per-request reset to Fibonacci unit
- FibStart  output  1  start to Fibonacci unit
- FibNumber  output  W  operand to Fibonacci unit
- FibResult  input  W  result from Fibonacci unit
- FibDone  input  1  completion level from Fibonacci unit
- OutValid  output  1  FIFO head valid
- OutReady  input  1  consumer accepts head
- OutIndex, OutResult  output  W  head entry
- Busy  output  1  high from accepted Go until the cycle SweepDone pulses or an abort
- SweepDone  output  1  one-cycle pulse after the final result is pushed
- Error  output  1  sticky; cleared by Rst or the next accepted Go

## Operation
- States: IDLE, LOAD, RUN, NEXT, FINISH.
- IDLE: FibRst=1, FibStart=0. On Go:
  - First>Last: set Error, stay IDLE.
  - Otherwise: latch idx=First and last=Last, clear Error, go to LOAD.
- LOAD, one cycle: FibRst=1, FibStart=0, FibNumber=idx. Go to RUN.
- RUN: FibRst=0, FibStart=1, FibNumber held at idx, watchdog counts.
  - FibDone=1: push {idx, FibResult} into the FIFO, go to NEXT.
  - Watchdog reaches TIMEOUT first: set Error, go to IDLE, nothing pushed, FIFO contents retained.
- NEXT:
  - idx==last: go to FINISH.
  - Else if FIFO not full: idx+1, go to LOAD.
  - Else wait in NEXT. FibRst=1 while waiting.
- FINISH, one cycle: SweepDone=1, Busy drops, go to IDLE.
- Only one request is ever outstanding, and the space check happens before LOAD, so a push can never hit a full FIFO.
- FIFO behaviour:
  - Show-ahead; head is on OutIndex/OutResult whenever OutValid=1.
  - Pop on OutValid&OutReady.
  - Push and pop in the same cycle are both honoured.
  - Pointers wrap modulo DEPTH; count range is 0..DEPTH.
- Go outside IDLE is ignored.
- First==Last produces one request. No arithmetic on results; FibResult is passed through at W bits.
- Reset values: FibRst=1, FibStart=0, FibNumber=0, OutValid=0, OutIndex=0, OutResult=0, Busy=0, SweepDone=0, Error=0. State=IDLE, FIFO empty, watchdog=0.
- Rst mid-sweep aborts immediately: no pending pushes, FIFO flushed.

## Timing
- Go sampled at edge t: LOAD during t+1, FibStart high from t+2.
- FibDone first sampled high at edge k: entry pushed at k, OutValid=1 from k+1 if the FIFO was empty, NEXT during k+1.
- Next LOAD during k+2 when space is available.
- Per-request overhead is 3 cycles beyond the unit's own latency.
- Final request: SweepDone pulses during k+2.
- Pop at edge p: the next entry, or OutValid=0, appears at p+1.
- Watchdog resets on LOAD entry and increments each RUN cycle. Abort happens at the edge where count==TIMEOUT.

## Structure
- Package fib_pkg holds:
  - Parameter defaults W, DEPTH, TIMEOUT.
  - State enum encoding IDLE/LOAD/RUN/NEXT/FINISH.
  - Entry typedef {index, result}, 2W bits.
- One sub-module: fib_result_fifo (synchronous FIFO, show-ahead, full/empty/count).
- The FSM, idx register and watchdog stay in fib_sweep_ctrl.

## Test plan
- Sweep First=1, Last=5, OutReady=1, real Fibonacci unit attached → stream (1,1),(2,1),(3,2),(4,3),(5,5). SweepDone pulses once, Busy falls the same cycle, Error=0.
- First=Last=10 → single entry (10,55), one FibRst/FibStart sequence. Number is stable through RUN.
- Sweep 1..8 with OutReady=0 and DEPTH=4 → FSM parks in NEXT after 4 pushes, OutValid=1 throughout. Raising OutReady drains and resumes, and all 8 entries arrive in order.
- Stub unit never asserts FibDone, TIMEOUT=15 → Error=1 exactly 15 RUN cycles after LOAD, return to IDLE, no push. The next valid Go clears Error.
- First=7, Last=3 → Error=1, Busy stays 0, FibStart never asserted.
- Rst asserted during RUN of sweep 1..20 with 2 entries buffered → next cycle all outputs at reset values, OutValid=0. Go after reset restarts cleanly from First.
